// File: rtl/branch_prediction_unit_if.sv
// branch_prediction_unit_if: fetch lookup and execute training signals of the branch predictor
interface branch_prediction_unit_if #(
    parameter int XLEN       = 32,
    parameter int INDEX_BITS = 6,
    parameter int CNT_WIDTH  = 16
);
    logic [XLEN-1:0]       PCF;
    logic                  PredTakenF;
    logic [INDEX_BITS-1:0] PHTIndexF;
    logic [INDEX_BITS-1:0] PHTIndexE;
    logic                  PredTakenE;
    logic [1:0]            BranchOpE;
    logic                  BranchTakenE;
    logic                  StallE;
    logic                  FlushE;
    logic                  MispredictE;
    logic [CNT_WIDTH-1:0]  BranchCount;
    logic [CNT_WIDTH-1:0]  MispredictCount;

    modport master (
        output PCF, PHTIndexE, PredTakenE, BranchOpE, BranchTakenE, StallE, FlushE,
        input  PredTakenF, PHTIndexF, MispredictE, BranchCount, MispredictCount
    );

    modport slave (
        input  PCF, PHTIndexE, PredTakenE, BranchOpE, BranchTakenE, StallE, FlushE,
        output PredTakenF, PHTIndexF, MispredictE, BranchCount, MispredictCount
    );
endinterface

// File: rtl/branch_prediction_unit.sv
// branch_prediction_unit: 2-bit PHT predictor with GHR and perf counters; define BPU_GSHARE_EN for gshare indexing
module branch_prediction_unit #(
    parameter int XLEN       = 32,
    parameter int INDEX_BITS = 6,
    parameter int GHR_BITS   = 6,
    parameter int CNT_WIDTH  = 16
) (
    input logic                     clk,
    input logic                     reset,
    branch_prediction_unit_if.slave bus
);
    localparam int ENTRIES = 1 << INDEX_BITS;

    logic [1:0]            pht_q [ENTRIES];
    logic [GHR_BITS-1:0]   ghr_q, ghr_d;
    logic [CNT_WIDTH-1:0]  bc_q, bc_d, mc_q, mc_d;
    logic [1:0]            ctr, ctr_d;
    logic [INDEX_BITS-1:0] idx_f;
    logic                  is_cond, valid;
    logic                  unused_pc;

    assign unused_pc = ^{bus.PCF[XLEN-1:INDEX_BITS+2], bus.PCF[1:0]};

`ifdef BPU_GSHARE_EN
    assign idx_f = bus.PCF[INDEX_BITS+1:2] ^ INDEX_BITS'(ghr_q);
`else
    assign idx_f = bus.PCF[INDEX_BITS+1:2];
`endif

    // Fetch lookup and execute-side misprediction flag, both purely combinational
    always_comb begin
        is_cond         = bus.BranchOpE == 2'b10;
        valid           = is_cond & ~bus.StallE & ~bus.FlushE & ~reset;
        bus.MispredictE = is_cond & ~bus.FlushE & (bus.PredTakenE != bus.BranchTakenE);
        bus.PHTIndexF   = idx_f;
        bus.PredTakenF  = pht_q[idx_f][1];
    end

    // Next values for the trained counter, history and saturating perf counters
    always_comb begin
        ctr   = pht_q[bus.PHTIndexE];
        ctr_d = bus.BranchTakenE ? ((ctr == 2'b11) ? ctr : ctr + 2'd1)
                                 : ((ctr == 2'b00) ? ctr : ctr - 2'd1);
        ghr_d = GHR_BITS'({ghr_q, bus.BranchTakenE});
        bc_d  = (&bc_q) ? bc_q : bc_q + CNT_WIDTH'(1);
        mc_d  = (bus.MispredictE && !(&mc_q)) ? mc_q + CNT_WIDTH'(1) : mc_q;
    end

    // State update only on a resolved, non-stalled, non-flushed conditional branch
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) pht_q[i] <= 2'b01;
            ghr_q <= '0;
            bc_q  <= '0;
            mc_q  <= '0;
        end else if (valid) begin
            pht_q[bus.PHTIndexE] <= ctr_d;
            ghr_q <= ghr_d;
            bc_q  <= bc_d;
            mc_q  <= mc_d;
        end
    end

    assign bus.BranchCount     = bc_q;
    assign bus.MispredictCount = mc_q;
endmodule

// File: tb/tb_branch_prediction_unit.sv
// tb_branch_prediction_unit: vector table with scoreboard plus reset, gshare-index and counter-saturation sequences
module tb_branch_prediction_unit;
    logic clk = 1'b0;
    logic reset, reset4;
    always #5 clk = ~clk;

    branch_prediction_unit_if #(.XLEN(32), .INDEX_BITS(6), .CNT_WIDTH(16)) bus ();
    branch_prediction_unit_if #(.XLEN(32), .INDEX_BITS(6), .CNT_WIDTH(4))  bus4 ();

    branch_prediction_unit #(.XLEN(32), .INDEX_BITS(6), .GHR_BITS(6), .CNT_WIDTH(16)) dut (
        .clk(clk), .reset(reset), .bus(bus.slave));
    branch_prediction_unit #(.XLEN(32), .INDEX_BITS(6), .GHR_BITS(6), .CNT_WIDTH(4)) dut4 (
        .clk(clk), .reset(reset4), .bus(bus4.slave));

    typedef struct {
        logic        rst;
        logic [5:0]  idx_f;
        logic [1:0]  op;
        logic [5:0]  idx_e;
        logic        pred_e, taken_e, stall, flush;
        logic        exp_pred_f, exp_mis;
        logic [15:0] exp_bc, exp_mc;
    } vec_t;

    vec_t vecs[20];
    vec_t sb[$];
    int checks = 0;
    int errors = 0;
    logic [5:0] ghr_m = '0;

    function automatic vec_t mk(input int rst, idx_f, op, idx_e, pred_e, taken_e, stall, flush,
                                input int pf, mis, bc, mc);
        vec_t v;
        v.rst = rst[0]; v.idx_f = idx_f[5:0]; v.op = op[1:0]; v.idx_e = idx_e[5:0];
        v.pred_e = pred_e[0]; v.taken_e = taken_e[0]; v.stall = stall[0]; v.flush = flush[0];
        v.exp_pred_f = pf[0]; v.exp_mis = mis[0]; v.exp_bc = bc[15:0]; v.exp_mc = mc[15:0];
        return v;
    endfunction

    function automatic logic [31:0] pc_for(input logic [5:0] idx);
`ifdef BPU_GSHARE_EN
        return {24'h0, idx ^ ghr_m, 2'b00};
`else
        return {24'h0, idx, 2'b00};
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        vec_t e;
        reset            = v.rst;
        bus.PCF          = pc_for(v.idx_f);
        bus.BranchOpE    = v.op;
        bus.PHTIndexE    = v.idx_e;
        bus.PredTakenE   = v.pred_e;
        bus.BranchTakenE = v.taken_e;
        bus.StallE       = v.stall;
        bus.FlushE       = v.flush;
        sb.push_back(v);
        @(negedge clk);
        e = sb.pop_front();
        chk("PHTIndexF", 32'(bus.PHTIndexF), 32'(e.idx_f));
        chk("PredTakenF", 32'(bus.PredTakenF), 32'(e.exp_pred_f));
        chk("MispredictE", 32'(bus.MispredictE), 32'(e.exp_mis));
        chk("BranchCount", 32'(bus.BranchCount), 32'(e.exp_bc));
        chk("MispredictCount", 32'(bus.MispredictCount), 32'(e.exp_mc));
        @(posedge clk);
        if (v.rst) ghr_m = '0;
        else if (v.op == 2'b10 && !v.stall && !v.flush) ghr_m = {ghr_m[4:0], v.taken_e};
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.PCF = '0; bus.BranchOpE = 2'b10; bus.PHTIndexE = 6'd5;
        bus.PredTakenE = 1'b1; bus.BranchTakenE = 1'b0; bus.StallE = 1'b0; bus.FlushE = 1'b0;
        @(posedge clk);
        #1;
        ghr_m = '0;
        reset = 1'b0;
    endtask

    initial begin
        vecs[0]  = mk(0,16,2,16,1,1,0,0, 0,0,0,0);
        vecs[1]  = mk(0,16,2,16,1,1,0,0, 1,0,1,0);
        vecs[2]  = mk(0,16,2,16,1,1,0,0, 1,0,2,0);
        vecs[3]  = mk(0,16,2,16,1,1,0,0, 1,0,3,0);
        vecs[4]  = mk(0,16,2,16,1,0,0,0, 1,1,4,0);
        vecs[5]  = mk(0,16,2,16,1,0,0,0, 1,1,5,1);
        vecs[6]  = mk(0,16,2,16,1,0,0,0, 0,1,6,2);
        vecs[7]  = mk(0,16,2,16,1,0,0,0, 0,1,7,3);
        vecs[8]  = mk(0,16,0,16,1,0,0,0, 0,0,8,4);
        vecs[9]  = mk(0,20,2,20,0,1,0,0, 0,1,8,4);
        vecs[10] = mk(0,20,2,20,0,1,0,0, 1,1,9,5);
        vecs[11] = mk(0,20,2,20,0,1,0,0, 1,1,10,6);
        vecs[12] = mk(0,20,1,20,0,1,0,0, 1,0,11,7);
        vecs[13] = mk(0,5,3,5,0,1,0,0,   0,0,11,7);
        vecs[14] = mk(0,5,2,5,0,1,1,0,   0,1,11,7);
        vecs[15] = mk(0,5,2,5,0,1,0,1,   0,0,11,7);
        vecs[16] = mk(0,5,2,5,1,1,0,0,   0,0,11,7);
        vecs[17] = mk(0,5,0,5,0,0,0,0,   1,0,12,7);
        vecs[18] = mk(0,8,2,8,0,1,0,0,   0,1,12,7);
        vecs[19] = mk(0,8,0,8,0,0,0,0,   1,0,13,8);

        reset4 = 1'b0;
        bus4.PCF = '0; bus4.BranchOpE = 2'b00; bus4.PHTIndexE = '0; bus4.PredTakenE = 1'b0;
        bus4.BranchTakenE = 1'b0; bus4.StallE = 1'b0; bus4.FlushE = 1'b0;

        @(posedge clk);
        #1;
        do_reset();
        for (int i = 0; i < 64; i++) apply(mk(0,i,0,0,0,1,0,0, 0,0,0,0));
        for (int i = 0; i < 20; i++) apply(vecs[i]);

        do_reset();
        apply(mk(0,0,2,0,1,1,0,0, 0,0,0,0));
        apply(mk(0,0,2,0,1,1,0,0, 1,0,1,0));
        apply(mk(0,0,2,0,1,0,0,0, 1,1,2,0));
        bus.PCF = 32'h20; bus.BranchOpE = 2'b00;
        @(negedge clk);
`ifdef BPU_GSHARE_EN
        chk("gshare_index", 32'(bus.PHTIndexF), 32'h0E);
`else
        chk("bimodal_index", 32'(bus.PHTIndexF), 32'h08);
`endif
        chk("count_after_TTN", 32'(bus.BranchCount), 32'd3);
        @(posedge clk);
        #1;

        reset4 = 1'b1;
        @(posedge clk);
        #1;
        reset4 = 1'b0;
        chk("cnt4_reset_bc", 32'(bus4.BranchCount), 32'd0);
        bus4.BranchOpE = 2'b10; bus4.PredTakenE = 1'b0; bus4.BranchTakenE = 1'b1;
        for (int i = 1; i <= 17; i++) begin
            @(posedge clk);
            #1;
            if (i == 14) chk("cnt4_bc_14", 32'(bus4.BranchCount), 32'hE);
            if (i == 15 || i == 17) begin
                chk("cnt4_bc_sat", 32'(bus4.BranchCount), 32'hF);
                chk("cnt4_mc_sat", 32'(bus4.MispredictCount), 32'hF);
            end
        end
        bus4.BranchOpE = 2'b00;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
